dcache_write_buffer: RTL and testbench
======================================

Name: dcache_write_buffer

Overview:
- Posted write-back buffer between the data cache miss port and the 256-bit line Data_Memory.
- Dirty-line evictions from the cache are acknowledged after one cycle and drained to memory in the background, so the refill read follows without waiting.
- Refill reads that hit a buffered line are served from the buffer. Reads that miss the buffer bypass pending writes.

Parameters:
- DEPTH, 4, number of line entries (power of 2, >=2)
- LINE_W, 256, line width in bits
- ADDR_W, 32, byte address width; lines are compared on addr[ADDR_W-1:5]

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- req_enable_i  in  1  cache request valid; held until req_ack_o
- req_write_i  in  1  1=line write (eviction), 0=line read (refill)
- req_addr_i  in  ADDR_W  line address, bits [4:0] ignored
- req_data_i  in  LINE_W  write line data
- req_ack_o  out  1  one-cycle completion pulse
- req_data_o  out  LINE_W  read line data, valid while req_ack_o=1
- mem_enable_o  out  1  memory request; held until mem_ack_i
- mem_write_o  out  1  memory write select
- mem_addr_o  out  ADDR_W  memory line address, bits [4:0]=0
- mem_data_o  out  LINE_W  memory write data
- mem_ack_i  in  1  memory completion pulse
- mem_data_i  in  LINE_W  memory read data, valid with mem_ack_i

Behaviour:
- Reset (rst_i=0, async): all entries invalid, count=0, head=tail=0, both FSMs idle. All outputs are 0. Any in-flight memory transaction is abandoned.
- Storage: circular FIFO of DEPTH entries {valid, line_addr, data}. Count is a registered value, 0..DEPTH. Pointers wrap modulo DEPTH.
- Request handshake: a request is sampled when req_enable_i=1 and the upstream FSM is in UP_IDLE. A request is consumed in its req_ack_o cycle. Enable still high in the following cycle is a new request. All outputs are registered.
- Upstream FSM states: UP_IDLE, UP_RDMEM, UP_ACK.
- Write, coalesce case: line_addr matches a valid non-head-in-flight entry. Data is overwritten in place, accepted even when full. Go to UP_ACK, so ack comes 1 cycle after sampling.
- Write, enqueue case: no match and count<DEPTH. Enqueue at tail, go to UP_ACK.
- Write, stall cases: no match and count==DEPTH, or the match is the head entry currently being drained. Stay in UP_IDLE with no ack and re-evaluate every cycle.
- Full-check uses registered count: a dequeue in the same cycle does not admit an enqueue until the next cycle.
- Read, buffer hit: youngest matching valid entry supplies req_data_o. This includes the head entry while it is draining. Go to UP_ACK, so ack comes 1 cycle after sampling.
- Read, buffer miss: go to UP_RDMEM and post a read request to the downstream FSM. On mem_ack_i, latch mem_data_i and go to UP_ACK. req_ack_o follows mem_ack_i by 1 cycle.
- UP_ACK: req_ack_o=1 for exactly one cycle, then return to UP_IDLE.
- Downstream FSM states: DN_IDLE, DN_WRITE, DN_READ.
- DN_IDLE priority: a pending read wins over draining; otherwise the head entry is drained if count>0.
- A started transaction always completes: a read arriving during DN_WRITE waits.
- DN_WRITE: mem_enable_o=1, mem_write_o=1, addr and data from head, all stable until mem_ack_i. On ack, invalidate head, head++, count--, and set mem_enable_o=0 in the next cycle.
- DN_READ: mem_enable_o=1, mem_write_o=0 until mem_ack_i. On ack, set mem_enable_o=0 in the next cycle.
- There is at least one idle cycle with mem_enable_o=0 between memory transactions.
- Ordering: memory observes writes in enqueue order. A read never returns memory data older than a buffered write to the same line.
- Simultaneous events: enqueue and dequeue in the same cycle update count by net 0. A coalesce to a non-head entry during a drain is allowed.
- Empty buffer with no request: mem_enable_o stays 0.

Test Plan:
- Memory model ack latency is 10 cycles. Write line 0x00000400, data 0xAA..AA -> req_ack_o 1 cycle after sampling. Memory write to 0x400 starts within 2 cycles and memory holds 0xAA..AA after ack.
- Write 0x400 (data 0x11..11), then immediately read 0x400 -> read acks in 1 cycle with 0x11..11 and no memory read is issued.
- Fill DEPTH=4 writes (0x000, 0x020, 0x040, 0x060), then write 0x080 -> no ack until the first drain completes. The ack follows the dequeue by >=1 cycle. Memory order is 0x000, 0x020, 0x040, 0x060, 0x080.
- While full, write 0x040 again with new data (non-head) -> acked in 1 cycle, count stays 4, and memory finally holds the new data at 0x040.
- Buffer holds 0x000 and 0x020, and memory line 0x100=0x55..55. Read 0x100 while the drain of 0x000 is in flight -> the 0x000 write completes, then the read is issued before 0x020. req_ack_o carries 0x55..55 1 cycle after mem_ack_i.
- Assert rst_i=0 mid DN_WRITE with count=3 -> all outputs 0 immediately and count=0. After release, a read of a previously buffered address goes to memory.

Source files
------------

// File: rtl/dcache_write_buffer.sv
// Posted write-back buffer between the data cache miss port and line memory.
// Evictions are queued and drained in the background; refill reads hit the queue or bypass it.
//
// state     | meaning
// UP_IDLE   | waiting for / evaluating a cache request
// UP_RDMEM  | refill read missed the buffer, waiting for memory
// UP_ACK    | one-cycle completion pulse to the cache
// DN_IDLE   | memory port free, picks read or drain
// DN_WRITE  | draining the head entry to memory
// DN_READ   | refill read in flight
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_enable_i,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [LINE_W-1:0] req_data_i,
    output logic              req_ack_o,
    output logic [LINE_W-1:0] req_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int LA_W = ADDR_W - 5;

    typedef enum logic [1:0] {UP_IDLE, UP_RDMEM, UP_ACK} up_state_t;
    typedef enum logic [1:0] {DN_IDLE, DN_WRITE, DN_READ} dn_state_t;

    up_state_t up_state, up_next;
    dn_state_t dn_state, dn_next;

    logic [DEPTH-1:0]  valid;
    logic [LA_W-1:0]   line_addr [DEPTH];
    logic [LINE_W-1:0] line_data [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic [LA_W-1:0]   rd_line;

    logic [LA_W-1:0]   line_req;
    logic              hit;
    logic [PW-1:0]     hit_idx, scan_idx;
    logic              sample, full, head_busy, dn_start_write;
    logic              do_enq, do_coal, rd_hit, rd_miss, do_deq, rd_done;

    logic              ack_d;
    logic [LINE_W-1:0] rdata_d;
    logic              men_d, mwr_d;
    logic [ADDR_W-1:0] maddr_d;
    logic [LINE_W-1:0] mdata_d;

    logic              unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[4:0];

    assign line_req = req_addr_i[ADDR_W-1:5];

    // Scan from oldest to youngest so the last match is the youngest entry.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = head;
        scan_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PW'(i);
            if (valid[scan_idx] && line_addr[scan_idx] == line_req) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    // Head counts as busy from the cycle the drain is chosen, so a coalesce
    // cannot slip into data that is already being copied to memory.
    assign dn_start_write = (dn_state == DN_IDLE) && (up_state != UP_RDMEM) && (count != CW'(0));
    assign head_busy      = (dn_state == DN_WRITE) || dn_start_write;

    assign sample  = (up_state == UP_IDLE) && req_enable_i;
    assign full    = (count == CW'(DEPTH));
    assign do_enq  = sample && req_write_i && !hit && !full;
    assign do_coal = sample && req_write_i && hit && !((hit_idx == head) && head_busy);
    assign rd_hit  = sample && !req_write_i && hit;
    assign rd_miss = sample && !req_write_i && !hit;
    assign do_deq  = (dn_state == DN_WRITE) && mem_ack_i;
    assign rd_done = (dn_state == DN_READ) && mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            up_state     <= UP_IDLE;
            dn_state     <= DN_IDLE;
            req_ack_o    <= 1'b0;
            req_data_o   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            up_state     <= up_next;
            dn_state     <= dn_next;
            req_ack_o    <= ack_d;
            req_data_o   <= rdata_d;
            mem_enable_o <= men_d;
            mem_write_o  <= mwr_d;
            mem_addr_o   <= maddr_d;
            mem_data_o   <= mdata_d;
        end
    end

    always_comb begin
        up_next = up_state;
        case (up_state)
            UP_IDLE: begin
                if (do_enq || do_coal || rd_hit) up_next = UP_ACK;
                else if (rd_miss)                up_next = UP_RDMEM;
            end
            UP_RDMEM: if (rd_done) up_next = UP_ACK;
            UP_ACK:   up_next = UP_IDLE;
            default:  up_next = UP_IDLE;
        endcase
    end

    always_comb begin
        ack_d   = (up_next == UP_ACK);
        rdata_d = '0;
        if (rd_hit)
            rdata_d = line_data[hit_idx];
        else if ((up_state == UP_RDMEM) && rd_done)
            rdata_d = mem_data_i;
    end

    always_comb begin
        dn_next = dn_state;
        case (dn_state)
            DN_IDLE: begin
                if (up_state == UP_RDMEM)  dn_next = DN_READ;
                else if (count != CW'(0))  dn_next = DN_WRITE;
            end
            DN_WRITE: if (mem_ack_i) dn_next = DN_IDLE;
            DN_READ:  if (mem_ack_i) dn_next = DN_IDLE;
            default:  dn_next = DN_IDLE;
        endcase
    end

    always_comb begin
        men_d   = 1'b0;
        mwr_d   = 1'b0;
        maddr_d = '0;
        mdata_d = '0;
        case (dn_next)
            DN_WRITE: begin
                men_d   = 1'b1;
                mwr_d   = 1'b1;
                maddr_d = {line_addr[head], 5'b0};
                mdata_d = line_data[head];
            end
            DN_READ: begin
                men_d   = 1'b1;
                maddr_d = {rd_line, 5'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rd_line <= '0;
        end else begin
            if (do_enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            if (do_deq) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count <= count + CW'(do_enq) - CW'(do_deq);
            if (rd_miss)
                rd_line <= line_req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            line_addr[tail] <= line_req;
            line_data[tail] <= req_data_i;
        end else if (do_coal) begin
            line_data[hit_idx] <= req_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer against a 10-cycle-latency line memory model.
module tb_dcache_write_buffer;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_enable_i = 1'b0;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [LW-1:0] req_data_i = '0;
    logic          req_ack_o;
    logic [LW-1:0] req_data_o;
    logic          mem_enable_o;
    logic          mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic          mem_ack_i = 1'b0;
    logic [LW-1:0] mem_data_i = '0;

    dcache_write_buffer #(.DEPTH(4), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_enable_i (req_enable_i),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_ack_o    (req_ack_o),
        .req_data_o   (req_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cycle = 0;
    always @(posedge clk_i) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] mem_model [int];
    logic [32:0]   txn_log [$];
    int            lat = 0;
    int            rd_cnt = 0;
    int            first_wr_ack_cycle = -1;
    int            last_rd_ack_cycle = -1;

    // Memory answers on the 10th cycle of a held request; inputs change on negedges.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            mem_ack_i = 1'b0;
            lat = 0;
        end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            lat = 0;
        end else if (mem_enable_o) begin
            lat++;
            if (lat == 10) begin
                mem_ack_i = 1'b1;
                txn_log.push_back({mem_write_o, mem_addr_o});
                if (mem_write_o) begin
                    mem_model[int'(mem_addr_o >> 5)] = mem_data_o;
                    if (first_wr_ack_cycle < 0) first_wr_ack_cycle = cycle;
                end else begin
                    rd_cnt++;
                    last_rd_ack_cycle = cycle;
                    mem_data_i = mem_model.exists(int'(mem_addr_o >> 5)) ? mem_model[int'(mem_addr_o >> 5)] : '0;
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output logic [LW-1:0] rdata, output int lat_c, output int ack_cyc);
        int n = 0;
        @(negedge clk_i);
        req_enable_i = 1'b1;
        req_write_i  = wr;
        req_addr_i   = a;
        req_data_i   = d;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!req_ack_o && n < 200);
        n_checks++;
        if (req_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout addr=%h ack=%b required 1", a, req_ack_o);
        end
        rdata   = req_data_o;
        lat_c   = n;
        ack_cyc = cycle;
        @(negedge clk_i);
        req_enable_i = 1'b0;
        req_write_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < 500) begin
            @(posedge clk_i); #1;
            n++;
            idle = mem_enable_o ? 0 : idle + 1;
        end
        n_checks++;
        if (idle < 3) begin
            n_fail++;
            $display("FAIL drain_timeout mem_enable=%b required idle", mem_enable_o);
        end
    endtask

    task automatic test_reset();
        @(posedge clk_i); #1;
        n_checks++;
        if ({req_ack_o, mem_enable_o, mem_write_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b required 000", {req_ack_o, mem_enable_o, mem_write_o});
        end
        n_checks++;
        if (req_data_o !== '0 || mem_data_o !== '0 || mem_addr_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data addr=%h required 0", mem_addr_o);
        end
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d required 0", dut.count);
        end
        #2 rst_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        n_checks++;
        if (mem_enable_o !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_idle mem_enable=%b required 0", mem_enable_o);
        end
    endtask

    task automatic test_write_drain();
        logic [LW-1:0] rd, aa;
        int lc, ac, k;
        aa = {32{8'hAA}};
        do_req(1'b1, 32'h400, aa, rd, lc, ac);
        n_checks++;
        if (lc != 1) begin
            n_fail++;
            $display("FAIL write_ack_latency got=%0d required 1", lc);
        end
        k = 0;
        while (!(mem_enable_o && mem_write_o && mem_addr_o == 32'h400) && k < 2) begin
            @(posedge clk_i); #1;
            k++;
        end
        n_checks++;
        if (!(mem_enable_o && mem_write_o && mem_addr_o == 32'h400 && mem_data_o == aa)) begin
            n_fail++;
            $display("FAIL drain_start en=%b wr=%b addr=%h required 1 1 00000400", mem_enable_o, mem_write_o, mem_addr_o);
        end
        wait_drain();
        n_checks++;
        if (mem_model[32'h400 >> 5] !== aa) begin
            n_fail++;
            $display("FAIL drain_data got=%h required all AA", mem_model[32'h400 >> 5]);
        end
    endtask

    task automatic test_read_hit();
        logic [LW-1:0] rd, d11;
        int lc, ac, r0;
        d11 = {32{8'h11}};
        r0 = rd_cnt;
        do_req(1'b1, 32'h400, d11, rd, lc, ac);
        do_req(1'b0, 32'h400, '0, rd, lc, ac);
        n_checks++;
        if (lc != 1 || rd !== d11) begin
            n_fail++;
            $display("FAIL read_hit lat=%0d data=%h required 1 all 11", lc, rd);
        end
        wait_drain();
        n_checks++;
        if (rd_cnt != r0 || mem_model[32'h400 >> 5] !== d11) begin
            n_fail++;
            $display("FAIL read_hit_mem reads=%0d required %0d", rd_cnt, r0);
        end
    endtask

    task automatic test_full_and_coalesce();
        logic [LW-1:0] rd, d77;
        logic [AW-1:0] a;
        int lc, ac, bad;
        d77 = {32{8'h77}};
        txn_log.delete();
        first_wr_ack_cycle = -1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            a = AW'(i * 32);
            do_req(1'b1, a, {32{8'(8'h01 + i)}}, rd, lc, ac);
            if (lc != 1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fill_latency slow_acks=%0d required 0", bad);
        end
        do_req(1'b1, 32'h040, d77, rd, lc, ac);
        n_checks++;
        if (lc != 1 || dut.count !== 3'd4) begin
            n_fail++;
            $display("FAIL coalesce_full lat=%0d count=%0d required 1 4", lc, dut.count);
        end
        do_req(1'b1, 32'h080, {32{8'h88}}, rd, lc, ac);
        n_checks++;
        if (first_wr_ack_cycle < 0 || ac - first_wr_ack_cycle < 2) begin
            n_fail++;
            $display("FAIL full_stall ack_cycle=%0d mem_ack_cycle=%0d required gap>=2", ac, first_wr_ack_cycle);
        end
        wait_drain();
        n_checks++;
        if (txn_log.size() != 5) begin
            n_fail++;
            $display("FAIL drain_count got=%0d required 5", txn_log.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 5; i++)
                if (txn_log[i] !== {1'b1, AW'(i * 32)}) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL drain_order first=%h last=%h required 000..080 in order", txn_log[0], txn_log[4]);
            end
        end
        n_checks++;
        if (mem_model[32'h040 >> 5] !== d77) begin
            n_fail++;
            $display("FAIL coalesce_data got=%h required all 77", mem_model[32'h040 >> 5]);
        end
    endtask

    task automatic test_read_bypass();
        logic [LW-1:0] rd, d55;
        int lc, ac;
        d55 = {32{8'h55}};
        mem_model[32'h100 >> 5] = d55;
        txn_log.delete();
        do_req(1'b1, 32'h000, {32{8'hB0}}, rd, lc, ac);
        do_req(1'b1, 32'h020, {32{8'hB2}}, rd, lc, ac);
        do_req(1'b0, 32'h100, '0, rd, lc, ac);
        n_checks++;
        if (rd !== d55) begin
            n_fail++;
            $display("FAIL miss_data got=%h required all 55", rd);
        end
        n_checks++;
        if (ac - last_rd_ack_cycle != 1) begin
            n_fail++;
            $display("FAIL miss_ack_gap got=%0d required 1", ac - last_rd_ack_cycle);
        end
        wait_drain();
        n_checks++;
        if (txn_log.size() != 3) begin
            n_fail++;
            $display("FAIL bypass_count got=%0d required 3", txn_log.size());
        end else begin
            n_checks++;
            if (txn_log[0] !== {1'b1, 32'h000} || txn_log[1] !== {1'b0, 32'h100} || txn_log[2] !== {1'b1, 32'h020}) begin
                n_fail++;
                $display("FAIL bypass_order got=%h %h %h required 100000000 000000100 100000020",
                         txn_log[0], txn_log[1], txn_log[2]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [LW-1:0] rd, dcc;
        int lc, ac, r0;
        dcc = {32{8'hCC}};
        mem_model[32'h220 >> 5] = dcc;
        do_req(1'b1, 32'h200, {32{8'hD0}}, rd, lc, ac);
        do_req(1'b1, 32'h220, {32{8'hD2}}, rd, lc, ac);
        do_req(1'b1, 32'h240, {32{8'hD4}}, rd, lc, ac);
        n_checks++;
        if (!(mem_enable_o && mem_write_o) || dut.count !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset en=%b wr=%b count=%0d required 1 1 3", mem_enable_o, mem_write_o, dut.count);
        end
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({req_ack_o, mem_enable_o, mem_write_o} !== 3'b000 || mem_addr_o !== '0 || mem_data_o !== '0 || req_data_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset en=%b wr=%b addr=%h required all 0", mem_enable_o, mem_write_o, mem_addr_o);
        end
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_count got=%0d required 0", dut.count);
        end
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        r0 = rd_cnt;
        do_req(1'b0, 32'h220, '0, rd, lc, ac);
        n_checks++;
        if (rd !== dcc || rd_cnt != r0 + 1) begin
            n_fail++;
            $display("FAIL post_reset_read data=%h reads=%0d required all CC %0d", rd, rd_cnt, r0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_write_drain();
        test_read_hit();
        test_full_and_coalesce();
        test_read_bypass();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
